branch_predict_unit: RTL and testbench

Parametrised branch predictor and resolver for the RV32I pipelined core. Fetch stage gets a same-cycle taken/target prediction from a direct-mapped BTB with saturating-counter history. Execute stage resolves the branch condition (now including unsigned compares) against the prediction carried down the pipe, drives the PC-source select and the flush, and trains the tables.

---
 rtl/branch_predict_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB/BHT fetch predictor with execute-stage resolver and trainer
// Optional statistics counters enabled by defining BRANCH_PRED_STATS_EN.
module branch_predict_unit #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] PCF,
  output logic            predTakenF,
  output logic [PC_W-1:0] predTargetF,
  input  logic            validE,
  input  logic [PC_W-1:0] PCE,
  input  logic [PC_W-1:0] targetE,
  input  logic [2:0]      branchE,
  input  logic [1:0]      jumpE,
  input  logic            zero,
  input  logic            neg,
  input  logic            ltu,
  input  logic            predTakenE,
  output logic [1:0]      PCSrcE,
  output logic            flushE,
  output logic [31:0]     branchCount,
  output logic [31:0]     mispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int unsigned WT_INT = 1 << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = WT_INT[CTR_W-1:0];
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - 1'b1;

  localparam logic [1:0] SRC_NONE   = 2'b00;
  localparam logic [1:0] SRC_TARGET = 2'b01;
  localparam logic [1:0] SRC_JALR   = 2'b10;
  localparam logic [1:0] SRC_SEQ    = 2'b11;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[PC_W-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[PC_W-1:IDX_W+2];

  logic unused_lsbs;
  assign unused_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Asynchronous read: a same-cycle write to this index is not bypassed.
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign predTakenF  = hit_f && ctr_q[idx_f][CTR_W-1];
  assign predTargetF = predTakenF ? target_q[idx_f] : '0;
  assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  logic is_cond, is_jal, is_jalr, cond_taken, taken_e;

  always_comb begin
    is_cond = (branchE != 3'b000) && (branchE != 3'b111);
    is_jal  = (jumpE == 2'b01);
    is_jalr = (jumpE == 2'b10);
    case (branchE)
      3'b001:  cond_taken = zero;
      3'b010:  cond_taken = ~zero;
      3'b011:  cond_taken = neg;
      3'b100:  cond_taken = zero | ~neg;
      3'b101:  cond_taken = ltu;
      3'b110:  cond_taken = ~ltu;
      default: cond_taken = 1'b0;
    endcase
    taken_e = is_jal | (is_cond & cond_taken);
  end

  always_comb begin
    PCSrcE = SRC_NONE;
    if (validE) begin
      if (is_jalr) begin
        PCSrcE = SRC_JALR;
      end else if (is_jal || is_cond) begin
        if (taken_e && !predTakenE)      PCSrcE = SRC_TARGET;
        else if (!taken_e && predTakenE) PCSrcE = SRC_SEQ;
      end else if (predTakenE) begin
        PCSrcE = SRC_SEQ;
      end
    end
  end

  assign flushE = (PCSrcE != SRC_NONE);

  logic             wr_en;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [PC_W-1:0]  ent_target_d;
  logic [CTR_W-1:0] ent_ctr_d;

  always_comb begin
    wr_en        = 1'b0;
    ent_valid_d  = valid_q[idx_e];
    ent_tag_d    = tag_q[idx_e];
    ent_target_d = target_q[idx_e];
    ent_ctr_d    = ctr_q[idx_e];
    if (validE && !is_jalr) begin
      if (is_jal) begin
        wr_en        = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = tag_e;
        ent_target_d = targetE;
        ent_ctr_d    = '1;
      end else if (is_cond) begin
        if (taken_e) begin
          wr_en        = 1'b1;
          ent_valid_d  = 1'b1;
          ent_tag_d    = tag_e;
          ent_target_d = targetE;
          if (!hit_e)                  ent_ctr_d = CTR_WT;
          else if (ctr_q[idx_e] != '1) ent_ctr_d = ctr_q[idx_e] + 1'b1;
        end else if (hit_e) begin
          wr_en = 1'b1;
          if (ctr_q[idx_e] != '0) ent_ctr_d = ctr_q[idx_e] - 1'b1;
        end
      end else if (predTakenE) begin
        // Fetch hit on a non-branch: drop the aliasing entry.
        wr_en       = 1'b1;
        ent_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[idx_e]  <= ent_valid_d;
      tag_q[idx_e]    <= ent_tag_d;
      target_q[idx_e] <= ent_target_d;
      ctr_q[idx_e]    <= ent_ctr_d;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (validE && (is_cond || is_jal || is_jalr)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (flushE) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount  = branch_cnt_q;
  assign mispredCount = mispred_cnt_q;
`else
  assign branchCount  = 32'd0;
  assign mispredCount = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed and randomized checks of branch_predict_unit against a table model
// Statistics expectations follow BRANCH_PRED_STATS_EN.
module tb_branch_predict_unit;

  localparam int ENT  = 16;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, targetE;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        validE, zero, neg, ltu, predTakenE;
  logic [2:0]  branchE;
  logic [1:0]  jumpE;
  logic [1:0]  PCSrcE;
  logic        flushE;
  logic [31:0] branchCount, mispredCount;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .PCF(PCF), .predTakenF(predTakenF), .predTargetF(predTargetF),
    .validE(validE), .PCE(PCE), .targetE(targetE), .branchE(branchE), .jumpE(jumpE),
    .zero(zero), .neg(neg), .ltu(ltu), .predTakenE(predTakenE),
    .PCSrcE(PCSrcE), .flushE(flushE), .branchCount(branchCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int unsigned m_tgt   [ENT];
  int          m_ctr   [ENT];
  int unsigned m_bc, m_mc;
  bit          m_live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_index(input int unsigned pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  function automatic bit m_pred(input int unsigned pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic bit m_cond_taken();
    case (branchE)
      3'd1: return zero;
      3'd2: return !zero;
      3'd3: return neg;
      3'd4: return zero || !neg;
      3'd5: return ltu;
      3'd6: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_src();
    bit cond = (branchE >= 3'd1) && (branchE <= 3'd6);
    bit tk;
    if (!validE) return 0;
    if (jumpE == 2'd2) return 2;
    if (cond || jumpE == 2'd1) begin
      tk = (jumpE == 2'd1) || m_cond_taken();
      if (tk && !predTakenE) return 1;
      if (!tk && predTakenE) return 3;
      return 0;
    end
    return predTakenE ? 3 : 0;
  endfunction

  task automatic drive(input bit r, input bit v, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic [2:0] br, input logic [1:0] jmp, input bit z, input bit n,
                       input bit l, input bit pt, input logic [31:0] pcf);
    rst = r; validE = v; PCE = pce; targetE = tgt; branchE = br; jumpE = jmp;
    zero = z; neg = n; ltu = l; predTakenE = pt; PCF = pcf;
  endtask

  // Leaves time at the falling edge with all outputs compared to the model.
  task automatic step();
    int s;
    @(negedge clk);
    if (m_live) begin
      s = m_src();
      chk("predTakenF", {31'd0, predTakenF}, {31'd0, m_pred(PCF)});
      chk("predTargetF", predTargetF, m_pred(PCF) ? m_tgt[m_index(PCF)] : 32'd0);
      chk("PCSrcE", {30'd0, PCSrcE}, s);
      chk("flushE", {31'd0, flushE}, {31'd0, s != 0});
`ifdef BRANCH_PRED_STATS_EN
      chk("branchCount", branchCount, m_bc);
      chk("mispredCount", mispredCount, m_mc);
`else
      chk("branchCount", branchCount, 32'd0);
      chk("mispredCount", mispredCount, 32'd0);
`endif
    end
  endtask

  task automatic tick();
    int  i, s;
    bit  cond, tk, hit;
    int unsigned tag;
    i    = m_index(PCE);
    tag  = PCE >> 6;
    hit  = m_hit(PCE);
    s    = m_src();
    cond = (branchE >= 3'd1) && (branchE <= 3'd6);
    tk   = (jumpE == 2'd1) || (cond && m_cond_taken());
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < ENT; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
      m_bc = 0; m_mc = 0; m_live = 1'b1;
    end else if (validE) begin
      if (jumpE == 2'd2) begin
      end else if (jumpE == 2'd1) begin
        m_valid[i] = 1'b1; m_tag[i] = tag; m_tgt[i] = targetE; m_ctr[i] = CMAX;
      end else if (cond) begin
        if (tk) begin
          m_ctr[i]   = hit ? ((m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1) : 2;
          m_valid[i] = 1'b1; m_tag[i] = tag; m_tgt[i] = targetE;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (predTakenE) begin
        m_valid[i] = 1'b0;
      end
      if (cond || jumpE == 2'd1 || jumpE == 2'd2) begin
        m_bc++;
        if (s != 0) m_mc++;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] hi;
    hi = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0;
    return hi | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); tick();

    // Reset state and a gated-off branch.
    drive(0, 0, 32'h40, 32'h80, 3'd1, 0, 1, 0, 0, 0, 32'h40);
    step();
    chk("rst_predTakenF", {31'd0, predTakenF}, 32'd0);
    chk("rst_predTargetF", predTargetF, 32'd0);
    chk("bubble_PCSrcE", {30'd0, PCSrcE}, 32'd0);
    tick();

    // Taken BEQ miss installs weakly taken.
    drive(0, 1, 32'h40, 32'h80, 3'd1, 0, 1, 0, 0, 0, 32'h40);
    step();
    chk("beq_miss_PCSrcE", {30'd0, PCSrcE}, 32'd1);
    chk("beq_miss_flushE", {31'd0, flushE}, 32'd1);
    tick();
    drive(0, 0, 32'h40, 32'h80, 3'd1, 0, 1, 0, 0, 0, 32'h40);
    step();
    chk("beq_pred_taken", {31'd0, predTakenF}, 32'd1);
    chk("beq_pred_target", predTargetF, 32'h80);
    tick();

    // Two not-taken resolutions walk the counter down.
    drive(0, 1, 32'h40, 32'h80, 3'd1, 0, 0, 0, 0, 1, 32'h40);
    step();
    chk("beq_nt_PCSrcE", {30'd0, PCSrcE}, 32'd3);
    tick();
    drive(0, 1, 32'h40, 32'h80, 3'd1, 0, 0, 0, 0, 0, 32'h40);
    step(); tick();
    drive(0, 0, 32'h40, 32'h80, 3'd0, 0, 0, 0, 0, 0, 32'h40);
    step();
    chk("beq_decayed", {31'd0, predTakenF}, 32'd0);
    tick();

    // Unsigned compares and JALR.
    drive(0, 1, 32'h100, 32'h180, 3'd5, 0, 0, 0, 1, 0, 32'h0);
    step();
    chk("bltu_PCSrcE", {30'd0, PCSrcE}, 32'd1);
    tick();
    drive(0, 1, 32'h104, 32'h180, 3'd6, 0, 0, 0, 1, 0, 32'h0);
    step();
    chk("bgeu_PCSrcE", {30'd0, PCSrcE}, 32'd0);
    tick();
    drive(0, 1, 32'h108, 32'h180, 3'd0, 2'd2, 0, 0, 0, 0, 32'h0);
    step();
    chk("jalr_PCSrcE", {30'd0, PCSrcE}, 32'd2);
    tick();

    // JAL install then alias invalidation.
    drive(0, 1, 32'h40, 32'h200, 3'd0, 2'd1, 0, 0, 0, 0, 32'h0);
    step(); tick();
    drive(0, 0, 32'h40, 32'h200, 3'd0, 0, 0, 0, 0, 0, 32'h40);
    step();
    chk("jal_pred_target", predTargetF, 32'h200);
    tick();
    drive(0, 1, 32'h40, 32'h0, 3'd0, 0, 0, 0, 0, 1, 32'h0);
    step();
    chk("alias_PCSrcE", {30'd0, PCSrcE}, 32'd3);
    tick();
    drive(0, 0, 32'h40, 32'h0, 3'd0, 0, 0, 0, 0, 0, 32'h40);
    step();
    chk("alias_cleared", {31'd0, predTakenF}, 32'd0);
    tick();

    // Statistics: 3 branches, 1 mispredict, 1 bubble.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); tick();
    drive(0, 1, 32'h500, 32'h600, 3'd1, 0, 1, 0, 0, 1, 32'h0);
    step(); tick();
    drive(0, 1, 32'h504, 32'h600, 3'd2, 0, 0, 0, 0, 0, 32'h0);
    step(); tick();
    drive(0, 1, 32'h508, 32'h700, 3'd0, 2'd1, 0, 0, 0, 1, 32'h0);
    step(); tick();
    drive(0, 0, 32'h50c, 32'h700, 3'd1, 0, 1, 0, 0, 0, 32'h0);
    step();
`ifdef BRANCH_PRED_STATS_EN
    chk("stats_branch", branchCount, 32'd3);
    chk("stats_mispred", mispredCount, 32'd1);
`endif
    tick();
    drive(1, 1, 32'h300, 32'h340, 3'd1, 0, 1, 0, 0, 0, 32'h0);
    step(); tick();
    drive(0, 0, 32'h300, 32'h340, 3'd0, 0, 0, 0, 0, 0, 32'h300);
    step();
    chk("rst_wins_pred", {31'd0, predTakenF}, 32'd0);
    chk("rst_wins_bc", branchCount, 32'd0);
    tick();

    // Randomized traffic on a small aliasing PC pool.
    for (int it = 0; it < 400; it++) begin
      logic [31:0] pce;
      logic [2:0]  br;
      logic [1:0]  jmp;
      bit          pt;
      pce = rand_pc();
      br  = 3'($urandom_range(0, 7));
      jmp = 2'($urandom_range(0, 3));
      if (jmp == 2'd1 || jmp == 2'd2) br = 3'd0;
      pt  = ($urandom_range(0, 1) == 1) ? m_pred(pce) : 1'($urandom_range(0, 1));
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, pce, $urandom & 32'hffff_fffc,
            br, jmp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pt, rand_pc());
      step(); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
